// File: rtl/dac_chan_sched.sv
// dac_chan_sched: per-channel sample hold slots granted round-robin to the DAC serializer,
// with a GAP_CYC idle gap after each frame. Define DAC_CHADDR_EN to put the channel index in dac_din[15:14].
module dac_chan_sched #(
    parameter int NCH     = 4,
    parameter int DW      = 16,
    parameter int GAP_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_vld,
    input  logic [NCH*DW-1:0] ch_data,
    output logic [NCH-1:0]    ch_rdy,
    output logic [15:0]       dac_din,
    output logic              dac_din_vld,
    input  logic              dac_rdy,
    output logic              busy,
    output logic              done,
    output logic [1:0]        done_ch
);
    localparam int GW = $clog2(GAP_CYC + 2);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t         state, state_nx;
    logic [DW-1:0]  hold [NCH];
    logic [NCH-1:0] pend;
    logic [1:0]     last, cur, g, idx;
    logic [GW-1:0]  gap_cnt;
    logic           issue, fin;

    // Scan from farthest to nearest so the first pending channel after last wins.
    always_comb begin
        g   = last;
        idx = last;
        for (int k = NCH; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % NCH);
            if (pend[idx]) g = idx;
        end
    end

    assign issue  = (state == IDLE) && (|pend) && dac_rdy;
    assign fin    = (state == BUSY) && !dac_din_vld && dac_rdy;
    assign ch_rdy = ~pend;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (issue) state_nx = BUSY;
            BUSY:    if (fin) state_nx = (GAP_CYC == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++)
            if (ch_vld[i] && !pend[i]) hold[i] <= ch_data[DW*i +: DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '0;
            last        <= 2'(NCH - 1);
            cur         <= '0;
            gap_cnt     <= '0;
            dac_din     <= '0;
            dac_din_vld <= 1'b0;
            done        <= 1'b0;
            done_ch     <= '0;
        end else begin
            dac_din_vld <= issue;
            done        <= fin;
            for (int i = 0; i < NCH; i++)
                if (ch_vld[i] && !pend[i]) pend[i] <= 1'b1;
            if (issue) begin
                pend[g] <= 1'b0;
                last    <= g;
                cur     <= g;
`ifdef DAC_CHADDR_EN
                dac_din <= {g, hold[g][13:0]};
`else
                dac_din <= hold[g];
`endif
            end
            if (fin) begin
                done_ch <= cur;
                gap_cnt <= GW'(GAP_CYC);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dac_chan_sched.sv
// tb_dac_chan_sched: scoreboard bench; issues and done pulses are checked against a round-robin
// model of the channel queue, plus directed timing checks. A second instance runs with GAP_CYC=0.
`timescale 1ns/1ps
module tb_dac_chan_sched;
    localparam int NCH = 4, DW = 16, GAP = 8;

    logic              clk = 0, rst_n = 0;
    logic [NCH-1:0]    ch_vld = '0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_rdy, ch_rdy0;
    logic [15:0]       dac_din, dac_din0;
    logic              dac_din_vld, dac_din_vld0, dac_rdy, dac_rdy0;
    logic              busy, busy0, done, done0;
    logic [1:0]        done_ch, done_ch0;

    int tests = 0, fails = 0, cyc = 0;
    int frame_len = 36, ser_cnt = 0, ser_cnt0 = 0;
    logic ser_hold = 0;

    typedef struct {int ch; logic [15:0] d;} item_t;
    item_t exp_q[$];
    int    done_q[$];
    int    model_last = NCH - 1;
    logic [15:0] exp_din = '0;
    int issue_cyc = -1, rdy_rise_cyc = -1, done_cyc = -1, issue0_cyc = -1, rdy0_rise_cyc = -1;
    logic prev_vld = 0, prev_rdy = 0, prev_rdy0 = 0;

    dac_chan_sched #(.NCH(NCH), .DW(DW), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .ch_vld(ch_vld), .ch_data(ch_data), .ch_rdy(ch_rdy),
        .dac_din(dac_din), .dac_din_vld(dac_din_vld), .dac_rdy(dac_rdy),
        .busy(busy), .done(done), .done_ch(done_ch));

    dac_chan_sched #(.NCH(NCH), .DW(DW), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ch_vld(ch_vld), .ch_data(ch_data), .ch_rdy(ch_rdy0),
        .dac_din(dac_din0), .dac_din_vld(dac_din_vld0), .dac_rdy(dac_rdy0),
        .busy(busy0), .done(done0), .done_ch(done_ch0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serializer models: busy frame_len cycles after each issue, ready drops with the strobe.
    assign dac_rdy  = !dac_din_vld && (ser_cnt == 0) && !ser_hold;
    assign dac_rdy0 = !dac_din_vld0 && (ser_cnt0 == 0);
    always @(posedge clk) begin
        ser_cnt  <= dac_din_vld  ? frame_len - 1 : (ser_cnt  > 0 ? ser_cnt  - 1 : 0);
        ser_cnt0 <= dac_din_vld0 ? frame_len - 1 : (ser_cnt0 > 0 ? ser_cnt0 - 1 : 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_word(int ch, logic [15:0] d);
`ifdef DAC_CHADDR_EN
        return {2'(ch), d[13:0]};
`else
        return d;
`endif
    endfunction

    // Monitor: pops the scoreboard on every issue and done pulse.
    always @(negedge clk) begin
        item_t e;
        if (rst_n) begin
            if (dac_din_vld) begin
                issue_cyc = cyc;
                check("vld_one_cycle", prev_vld, 0);
                check("vld_after_rdy", prev_rdy, 1);
                if (exp_q.size() == 0) check("unexpected_issue", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    exp_din = exp_word(e.ch, e.d);
                    check("issue_data", dac_din, exp_din);
                    done_q.push_back(e.ch);
                end
            end else check("din_stable", dac_din, exp_din);
            if (done) begin
                done_cyc = cyc;
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_ch", done_ch, done_q.pop_front());
            end
            if (dac_rdy && !prev_rdy) rdy_rise_cyc = cyc;
            if (dac_din_vld0) issue0_cyc = cyc;
            if (dac_rdy0 && !prev_rdy0) rdy0_rise_cyc = cyc;
        end
        prev_vld  = dac_din_vld;
        prev_rdy  = dac_rdy;
        prev_rdy0 = dac_rdy0;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(int c, logic [15:0] v);
        item_t it;
        it.ch = c;
        it.d  = v;
        exp_q.push_back(it);
    endtask

    // Channels loaded together into empty slots leave in rotation order after the last grant.
    task automatic expect_rr(logic [NCH-1:0] mask, logic [15:0] d [NCH]);
        int base = model_last;
        for (int k = 1; k <= NCH; k++) begin
            int c = (base + k) % NCH;
            if (mask[c]) begin
                push_exp(c, d[c]);
                model_last = c;
            end
        end
    endtask

    task automatic load(logic [NCH-1:0] mask, logic [15:0] d [NCH]);
        ch_vld = mask;
        for (int i = 0; i < NCH; i++) ch_data[DW*i +: DW] = d[i];
        tick(1);
        ch_vld = '0;
    endtask

    task automatic wait_issue(int left);
        int n = 0;
        while (exp_q.size() > left && n < 2000) begin tick(1); n++; end
        check("issue_timeout", n < 2000, 1);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((exp_q.size() != 0 || busy || !dac_rdy) && n < 2000) begin tick(1); n++; end
        check("quiet_timeout", n < 2000, 1);
    endtask

    task automatic check_reset_vals();
        check("rst_ch_rdy", ch_rdy, 4'hF);
        check("rst_dac_din", dac_din, 0);
        check("rst_dac_din_vld", dac_din_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_ch", done_ch, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        exp_q.delete();
        done_q.delete();
        model_last = NCH - 1;
        exp_din = '0;
        tick(2);
        rst_n = 1;
        tick(1);
    endtask

    initial begin
        logic [15:0] d [NCH];
        logic [NCH-1:0] mask;
        int c;
        rst_n = 0;
        tick(2);
        check_reset_vals();
        do_reset();

        // Single issue with two-cycle latency
        d = '{16'hA5C3, 16'h0, 16'h0, 16'h0};
        c = cyc;
        expect_rr(4'b0001, d);
        load(4'b0001, d);
        check("t1_rdy0_low", ch_rdy[0], 0);
        check("t1_vld_early", dac_din_vld, 0);
        tick(1);
        check("t1_vld", dac_din_vld, 1);
        check("t1_din", dac_din, exp_word(0, 16'hA5C3));
        check("t1_busy", busy, 1);
        check("t1_latency", cyc - c, 2);
        check("t1_rdy0_back", ch_rdy[0], 1);
        tick(1);
        check("t1_vld_width", dac_din_vld, 0);
        wait_quiet();

        // Round-robin: 2,0,3 together, then 0 and 1 reloaded after channel 0 is granted
        do_reset();
        d = '{16'h0AAA, 16'h1BBB, 16'h2CCC, 16'h3DDD};
        push_exp(0, 16'h0AAA);
        load(4'b1101, d);
        wait_issue(0);
        check("t2_refill_rdy", ch_rdy[0], 1);
        check("t2_pend_rdy", ch_rdy & 4'b1100, 0);
        d = '{16'h0EEE, 16'h1FFF, 16'h2CCC, 16'h3DDD};
        push_exp(1, 16'h1FFF);
        push_exp(2, 16'h2CCC);
        push_exp(3, 16'h3DDD);
        push_exp(0, 16'h0EEE);
        model_last = 0;
        load(4'b0011, d);
        wait_quiet();

        // Gap enforcement: 36-cycle frames, GAP and zero-gap instances
        do_reset();
        frame_len = 36;
        d = '{16'h1234, 16'h5678, 16'h0, 16'h0};
        expect_rr(4'b0011, d);
        load(4'b0011, d);
        wait_issue(0);
        check("t3_done_after_rdy", done_cyc - rdy_rise_cyc, 1);
        check("t3_gap_spacing", issue_cyc - rdy_rise_cyc, GAP + 2);
        check("t3_gap0_spacing", issue0_cyc - rdy0_rise_cyc, 2);
        wait_quiet();

        // Back-pressure
        ser_hold = 1;
        d = '{16'h0, 16'hBEEF, 16'hCAFE, 16'h0};
        expect_rr(4'b0110, d);
        load(4'b0110, d);
        for (int i = 0; i < 12; i++) begin
            check("t4_no_vld", dac_din_vld, 0);
            check("t4_rdy_low", ch_rdy & 4'b0110, 0);
            tick(1);
        end
        ser_hold = 0;
        check("t4_vld_same_cycle", dac_din_vld, 0);
        tick(1);
        check("t4_vld_next_cycle", dac_din_vld, 1);
        wait_quiet();

        // Reset in BUSY with two channels still pending
        d = '{16'h1111, 16'h2222, 16'h3333, 16'h0};
        expect_rr(4'b0111, d);
        load(4'b0111, d);
        wait_issue(2);
        tick(2);
        check("t5_busy_before", busy, 1);
        #2 rst_n = 0;
        #1 check_reset_vals();
        exp_q.delete();
        done_q.delete();
        model_last = NCH - 1;
        exp_din = '0;
        tick(2);
        rst_n = 1;
        tick(60);
        check("t5_idle_after", busy, 0);
        check("t5_rdy_after", ch_rdy, 4'hF);
        wait_quiet();

        // Address insertion corner values
        d = '{16'h0, 16'hFFFF, 16'h0, 16'hFFFF};
        expect_rr(4'b1000, d);
        load(4'b1000, d);
        wait_quiet();
        expect_rr(4'b0010, d);
        load(4'b0010, d);
        wait_quiet();

        // Randomized batches
        for (int it = 0; it < 30; it++) begin
            wait_quiet();
            frame_len = $urandom_range(1, 40);
            mask = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int i = 0; i < NCH; i++) d[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            check("rand_slots_empty", ch_rdy, 4'hF);
            expect_rr(mask, d);
            load(mask, d);
        end
        wait_quiet();
        tick(2);
        check("exp_q_drained", exp_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
